// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared frame/clock-tap constants for the audio blocks
package audio_pkg;

    localparam int FRAME_LOG2 = 10;
    localparam int SLOT_LOG2  = 4;
    localparam int MCLK_BIT   = 1;
    localparam int SCK_BIT    = 3;
    localparam int LRCK_BIT   = 9;

    // 64 slots per frame, 32 per channel half
    localparam int SLOT_IDX_W = FRAME_LOG2 - SLOT_LOG2;
    localparam int HALF_IDX_W = SLOT_IDX_W - 1;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } channel_e;

endpackage

// File: rtl/i2s_clk_div.sv
// rtl/i2s_clk_div.sv - free-running frame counter with mclk/sck/lrck register taps
module i2s_clk_div
    import audio_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    output logic [FRAME_LOG2-1:0] cnt,
    output logic                  mclk,
    output logic                  sck,
    output logic                  lrck
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Clocks are plain counter bits so they cannot glitch.
    assign mclk = cnt[MCLK_BIT];
    assign sck  = cnt[SCK_BIT];
    assign lrck = cnt[LRCK_BIT];

endmodule

// File: rtl/i2s_audio_tx.sv
// rtl/i2s_audio_tx.sv - I2S transmitter: frame latch, slot bit select and sdin register
module i2s_audio_tx
    import audio_pkg::*;
#(
    parameter int SAMPLE_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] left_in,
    input  logic [SAMPLE_W-1:0] right_in,
    input  logic                mute,
    output logic                sample_tick,
    output logic                audio_mclk,
    output logic                audio_sck,
    output logic                audio_lrck,
    output logic                audio_sdin
);

    logic [FRAME_LOG2-1:0] cnt;
    logic [SAMPLE_W-1:0]   hold_left;
    logic [SAMPLE_W-1:0]   hold_right;
    logic                  frame_end;
    logic                  slot_end;
    logic [SLOT_IDX_W-1:0] next_slot;
    logic [HALF_IDX_W-1:0] next_k;
    channel_e              next_ch;
    logic [31:0]           word_ext;
    logic [HALF_IDX_W-1:0] bit_idx;
    logic                  next_bit;

    i2s_clk_div u_clk_div (
        .clk  (clk),
        .rst  (rst),
        .cnt  (cnt),
        .mclk (audio_mclk),
        .sck  (audio_sck),
        .lrck (audio_lrck)
    );

    assign frame_end   = &cnt;
    assign slot_end    = &cnt[SLOT_LOG2-1:0];
    assign sample_tick = frame_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_left  <= '0;
            hold_right <= '0;
        end else if (frame_end) begin
            hold_left  <= mute ? '0 : left_in;
            hold_right <= mute ? '0 : right_in;
        end
    end

    // sdin is loaded at the end of each slot with the bit for the slot about to start.
    assign next_slot = cnt[FRAME_LOG2-1:SLOT_LOG2] + 1'b1;
    assign next_k    = next_slot[HALF_IDX_W-1:0];
    assign next_ch   = channel_e'(next_slot[SLOT_IDX_W-1]);

    // Left-justify the word in 32 bits; k beyond SAMPLE_W then lands in zero padding.
    assign word_ext = {(next_ch == CH_RIGHT) ? hold_right : hold_left,
                       {(32-SAMPLE_W){1'b0}}};
    assign bit_idx  = ~(next_k - 1'b1);

    always_comb begin
        next_bit = 1'b0;
        if (next_k != '0) begin
            next_bit = word_ext[bit_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            audio_sdin <= 1'b0;
        end else if (slot_end) begin
            audio_sdin <= next_bit;
        end
    end

endmodule

// File: tb/tb_i2s_audio_tx.sv
// tb/tb_i2s_audio_tx.sv - randomized bench for i2s_audio_tx with a frame-level reference model
module tb_i2s_audio_tx;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         mute = 1'b0;
    logic [W-1:0] left_in = '0;
    logic [W-1:0] right_in = '0;
    logic         sample_tick, audio_mclk, audio_sck, audio_lrck, audio_sdin;

    int checks = 0;
    int fails  = 0;

    i2s_audio_tx #(.SAMPLE_W(W)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .left_in     (left_in),
        .right_in    (right_in),
        .mute        (mute),
        .sample_tick (sample_tick),
        .audio_mclk  (audio_mclk),
        .audio_sck   (audio_sck),
        .audio_lrck  (audio_lrck),
        .audio_sdin  (audio_sdin)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position in frame plus the samples held for the frame.
    int          mc = 0;
    int unsigned ml = 0;
    int unsigned mr = 0;
    bit          valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            mc    <= 0;
            ml    <= 0;
            mr    <= 0;
            valid <= 1'b1;
        end else begin
            if (mc == 1023) begin
                ml <= mute ? 0 : int'(left_in);
                mr <= mute ? 0 : int'(right_in);
            end
            mc <= (mc + 1) % 1024;
        end
    end

    function automatic logic exp_sdin(input int c, input int unsigned l, input int unsigned r);
        int          s;
        int          k;
        int unsigned samp;
        s    = c / 16;
        k    = s % 32;
        samp = (s >= 32) ? r : l;
        if (k >= 1 && k <= W) return logic'((samp >> (W - k)) & 1);
        return 1'b0;
    endfunction

    logic [63:0] frame_bits = '0;
    logic [63:0] last_frame = '0;

    always @(negedge clk) begin
        if (valid) begin
            chk("mclk", 64'(audio_mclk), 64'((mc >> 1) & 1));
            chk("sck",  64'(audio_sck),  64'((mc >> 3) & 1));
            chk("lrck", 64'(audio_lrck), 64'((mc >> 9) & 1));
            chk("tick", 64'(sample_tick), 64'(mc == 1023));
            chk("sdin", 64'(audio_sdin), 64'(exp_sdin(mc, ml, mr)));
            if (mc % 16 == 8) frame_bits = {frame_bits[62:0], audio_sdin};
            if (mc == 1023) last_frame = frame_bits;
        end
    end

    task automatic wait_cnt(input int target);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (mc != target && n < 2100);
        if (mc != target) begin
            checks++;
            fails++;
            $display("FAIL wait_cnt: timed out at cnt %0d waiting for %0d", mc, target);
        end
    endtask

    task automatic get_frame(output logic [63:0] f);
        wait_cnt(1023);
        @(negedge clk);
        f = last_frame;
    endtask

    logic [63:0] f;
    int first_lrck, first_tick;
    int r_mclk, r_sck, r_lrck, bad_sdin;
    logic p_mclk, p_sck, p_lrck, p_sdin;

    initial begin
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_sdin", 64'(audio_sdin), 64'd0);
        chk("rst_lrck", 64'(audio_lrck), 64'd0);
        chk("rst_sck",  64'(audio_sck),  64'd0);
        chk("rst_mclk", 64'(audio_mclk), 64'd0);
        chk("rst_tick", 64'(sample_tick), 64'd0);
        rst      = 1'b0;
        left_in  = 16'hB000;
        right_in = 16'h5FFF;

        first_lrck = -1;
        first_tick = -1;
        for (int i = 1; i <= 1023; i++) begin
            @(negedge clk);
            if (audio_lrck === 1'b1 && first_lrck < 0) first_lrck = i;
            if (sample_tick === 1'b1 && first_tick < 0) first_tick = i;
        end
        chk("first_lrck_rise", 64'(first_lrck), 64'd512);
        chk("first_tick", 64'(first_tick), 64'd1023);
        @(negedge clk);
        chk("frame1_zero", last_frame, 64'h0);

        get_frame(f);
        chk("frame2_serial", f, 64'h5800_0000_2FFF_8000);

        r_mclk = 0; r_sck = 0; r_lrck = 0; bad_sdin = 0;
        @(negedge clk);
        p_mclk = audio_mclk; p_sck = audio_sck; p_lrck = audio_lrck; p_sdin = audio_sdin;
        for (int i = 0; i < 4096; i++) begin
            @(negedge clk);
            if (!p_mclk && audio_mclk) r_mclk++;
            if (!p_sck && audio_sck) r_sck++;
            if (!p_lrck && audio_lrck) r_lrck++;
            if (p_sdin !== audio_sdin && !(p_sck && !audio_sck)) bad_sdin++;
            p_mclk = audio_mclk; p_sck = audio_sck; p_lrck = audio_lrck; p_sdin = audio_sdin;
        end
        chk("mclk_rises", 64'(r_mclk), 64'd1024);
        chk("sck_rises",  64'(r_sck),  64'd256);
        chk("lrck_rises", 64'(r_lrck), 64'd4);
        chk("sdin_off_sck_fall", 64'(bad_sdin), 64'd0);

        left_in  = 16'hFFFF;
        right_in = 16'h0000;
        get_frame(f);
        wait_cnt(500);
        left_in = 16'h0001;
        get_frame(f);
        chk("latch_hold_ffff", f, 64'h7FFF_8000_0000_0000);
        get_frame(f);
        chk("latch_next_0001", f, 64'h0000_8000_0000_0000);

        left_in  = 16'h7FFF;
        right_in = 16'h1234;
        mute     = 1'b1;
        get_frame(f);
        wait_cnt(100);
        mute = 1'b0;
        get_frame(f);
        chk("mute_frame", f, 64'h0);
        get_frame(f);
        chk("unmute_frame", f, 64'h3FFF_8000_091A_0000);

        wait_cnt(300);
        rst      = 1'b1;
        left_in  = 16'hAAAA;
        right_in = 16'h5555;
        @(negedge clk);
        chk("midrst_cnt",  64'(u_dut.cnt), 64'd0);
        chk("midrst_sdin", 64'(audio_sdin), 64'd0);
        chk("midrst_lrck", 64'(audio_lrck), 64'd0);
        chk("midrst_sck",  64'(audio_sck),  64'd0);
        chk("midrst_mclk", 64'(audio_mclk), 64'd0);
        rst = 1'b0;
        get_frame(f);
        chk("midrst_restart_zero", f, 64'h0);
        get_frame(f);
        chk("midrst_next", f, 64'h5555_0000_2AAA_8000);

        for (int n = 0; n < 8; n++) begin
            wait_cnt(int'($urandom_range(0, 1022)));
            left_in  = W'($urandom);
            right_in = W'($urandom);
            mute     = ($urandom_range(0, 3) == 0);
            if (n == 5) begin
                wait_cnt(int'($urandom_range(20, 1000)));
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        get_frame(f);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
